exe_mem_stage: RTL and testbench
================================

// Module: exe_mem_stage
// PURPOSE
//   Pipeline boundary directly downstream of the execute-stage ALU.
//   - Registers the ALU result, store data, destination and MEM/WB control into the EXE/MEM latch.
//   - Owns the architectural status register SR = {N,Z,C,V}.
//     - Feeds SR.C back to the ALU carry input.
//     - Exports SR to the condition-check logic.
//   - Keeps a retired-instruction counter for debug.
// PARAMETERS
//   DATA_W  32  datapath width (ALU result, store data)
//   DEST_W  4   register-file destination index width
//   CNT_W   32  width of the retired-instruction counter
// PORTS
//   clk         in   1       clock; all state updates on rising edge
//   rst         in   1       synchronous, active-high reset
//   freeze      in   1       hazard stall: hold every register this cycle
//   flush       in   1       kill the instruction currently in EXE
//   in_valid    in   1       EXE stage holds a real instruction
//   in_s        in   1       instruction's S bit (update flags)
//   in_wb_en    in   1       writeback enable
//   in_mem_r    in   1       memory read enable
//   in_mem_w    in   1       memory write enable
//   in_dest     in   DEST_W  destination register index
//   alu_res     in   DATA_W  ALU out
//   alu_n/z/c/v in   1 each  ALU NOut/ZOut/COut/VOut
//   in_val_rm   in   DATA_W  store data (Rm value)
//   out_valid   out  1       MEM stage holds a real instruction
//   out_wb_en   out  1       registered wb enable
//   out_mem_r   out  1       registered memory read enable
//   out_mem_w   out  1       registered memory write enable
//   out_dest    out  DEST_W  registered destination index
//   out_res     out  DATA_W  registered ALU result / address
//   out_val_rm  out  DATA_W  registered store data
//   sr          out  4       status register {N,Z,C,V}
//   carry_out   out  1       sr[1]; drives ALU carry input
//   retired     out  CNT_W   count of instructions accepted into MEM
// BEHAVIOUR
//   Per-edge priority: rst > flush > freeze > load.
//   - rst:
//     - All outputs 0.
//     - sr = 4'b0000, retired = 0.
//   - flush (freeze ignored):
//     - Bubble: out_valid, out_wb_en, out_mem_r and out_mem_w go to 0.
//     - out_res, out_val_rm and out_dest keep their previous values.
//     - sr and retired unchanged.
//   - freeze && !flush: every register, sr and retired hold. No flag update, so a
//     stalled instruction re-presented later updates flags exactly once.
//   - load, in_valid=1:
//     - All out_* take the in_* / alu_res values; out_valid=1.
//     - retired increments; wraps modulo 2^CNT_W.
//   - load, in_valid=0: behaves as flush (bubble); retired unchanged.
//   Status register:
//   - Written only on a load edge with in_valid && in_s.
//   - New value: sr <= {alu_n, alu_z, alu_c, alu_v}. All four bits are written
//     together, never partially.
//   Timing:
//   - Latency: 1 cycle from EXE inputs to out_* and to sr.
//   - carry_out is combinational from sr, so an ADC/SBC issued in the cycle after a
//     flag-setting instruction sees the new C.
//   - Control enables are forced to 0 whenever out_valid=0, so downstream never
//     writes memory or the register file from a bubble.
//   - rst asserted mid-stream overrides freeze/flush in the same cycle; first
//     post-reset load behaves as from power-up.
// STRUCTURE
//   Shared package (with the ALU):
//   - SR bit indices SR_N=3, SR_Z=2, SR_C=1, SR_V=0.
//   - Widths DATA_W/DEST_W.
//   Sub-module: status_reg
//   - 4-bit register with rst and a write enable; instantiated once.
//   - Reused by any later flag-owning stage.
//   - Pipeline latch and retired counter stay inline.
// TESTING
//   - Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, sr=0, retired=0.
//   - Load with flags:
//     - in_valid=1, in_s=1, alu_res=32'h8000_0000, n=1,z=0,c=1,v=1
//       -> next cycle out_res=32'h8000_0000, sr=4'b1011, carry_out=1, retired=1.
//   - No-S instruction: in_s=0, alu_z=1 -> sr unchanged; out_* loaded; retired +1.
//   - Freeze: freeze=1 for 3 cycles with changing inputs, in_s=1
//     -> out_*, sr and retired identical on all 3 cycles; after release one load,
//        flags written once.
//   - Flush/freeze together: flush=1, freeze=1, in_valid=1, in_mem_w=1
//     -> out_valid=0, out_mem_w=0, sr unchanged, retired unchanged.
//   - Counter wrap: CNT_W=4, 17 valid loads -> retired=1.

Source files
------------

// File: rtl/exe_mem_stage_pkg.sv
// Shared definitions for the execute stage and the EXE/MEM boundary:
// status-register bit positions and default datapath widths.
package exe_mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int DEST_W = 4;

    // Bit positions inside sr = {N,Z,C,V}
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

endpackage

// File: rtl/exe_mem_stage_status_reg.sv
// Four-bit architectural status register {N,Z,C,V}.
// All four flags are written together when we is high; never partially.
module status_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Clear on reset, otherwise capture the whole flag nibble on write enable
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'b0000;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exe_mem_stage.sv
// EXE/MEM pipeline boundary: latches ALU result, store data, destination and
// MEM/WB control; owns the status register and a retired-instruction counter.
//
// Flow control: in_valid marks a real instruction in EXE. An instruction is
// accepted into MEM on a clock edge where rst=0, flush=0, freeze=0 and
// in_valid=1. freeze holds everything (the instruction will be re-presented);
// flush or a non-valid input inserts a bubble. Priority: rst > flush > freeze.
module exe_mem_stage
    import exe_mem_stage_pkg::*;
#(
    parameter int DATA_W = exe_mem_stage_pkg::DATA_W,
    parameter int DEST_W = exe_mem_stage_pkg::DEST_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_s,
    input  logic              in_wb_en,
    input  logic              in_mem_r,
    input  logic              in_mem_w,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic [DATA_W-1:0] in_val_rm,
    output logic              out_valid,
    output logic              out_wb_en,
    output logic              out_mem_r,
    output logic              out_mem_w,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_res,
    output logic [DATA_W-1:0] out_val_rm,
    output logic [3:0]        sr,
    output logic              carry_out,
    output logic [CNT_W-1:0]  retired
);

    logic              valid_q;
    logic              wb_en_q;
    logic              mem_r_q;
    logic              mem_w_q;
    logic [DEST_W-1:0] dest_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] val_rm_q;
    logic [CNT_W-1:0]  retired_q;
    logic              accept;
    logic              bubble;
    logic              sr_we;
    logic [3:0]        sr_d;

    // Classify this edge: accept a real instruction, insert a bubble, or hold
    always_comb begin
        accept = !flush && !freeze && in_valid;
        bubble = flush || (!freeze && !in_valid);
        sr_we  = accept && in_s;
        sr_d   = 4'b0000;
        sr_d[SR_N] = alu_n;
        sr_d[SR_Z] = alu_z;
        sr_d[SR_C] = alu_c;
        sr_d[SR_V] = alu_v;
    end

    // EXE/MEM latch and retired counter; a bubble clears only valid/control,
    // leaving the data fields at their last values
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            dest_q    <= '0;
            res_q     <= '0;
            val_rm_q  <= '0;
            retired_q <= '0;
        end else if (bubble) begin
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
        end else if (accept) begin
            valid_q   <= 1'b1;
            wb_en_q   <= in_wb_en;
            mem_r_q   <= in_mem_r;
            mem_w_q   <= in_mem_w;
            dest_q    <= in_dest;
            res_q     <= alu_res;
            val_rm_q  <= in_val_rm;
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    status_reg u_status_reg (
        .clk (clk),
        .rst (rst),
        .we  (sr_we),
        .d   (sr_d),
        .q   (sr)
    );

    // Outputs; control enables are gated by valid so a bubble never writes
    always_comb begin
        out_valid  = valid_q;
        out_wb_en  = wb_en_q & valid_q;
        out_mem_r  = mem_r_q & valid_q;
        out_mem_w  = mem_w_q & valid_q;
        out_dest   = dest_q;
        out_res    = res_q;
        out_val_rm = val_rm_q;
        carry_out  = sr[SR_C];
        retired    = retired_q;
    end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed self-checking bench for exe_mem_stage (counter narrowed to 4 bits
// so the wrap is reachable).
module tb_exe_mem_stage;

    localparam int DATA_W = 32;
    localparam int DEST_W = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              freeze;
    logic              flush;
    logic              in_valid;
    logic              in_s;
    logic              in_wb_en;
    logic              in_mem_r;
    logic              in_mem_w;
    logic [DEST_W-1:0] in_dest;
    logic [DATA_W-1:0] alu_res;
    logic              alu_n;
    logic              alu_z;
    logic              alu_c;
    logic              alu_v;
    logic [DATA_W-1:0] in_val_rm;
    logic              out_valid;
    logic              out_wb_en;
    logic              out_mem_r;
    logic              out_mem_w;
    logic [DEST_W-1:0] out_dest;
    logic [DATA_W-1:0] out_res;
    logic [DATA_W-1:0] out_val_rm;
    logic [3:0]        sr;
    logic              carry_out;
    logic [CNT_W-1:0]  retired;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Clock
    always #5 clk = ~clk;

    exe_mem_stage #(
        .DATA_W (DATA_W),
        .DEST_W (DEST_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_s       (in_s),
        .in_wb_en   (in_wb_en),
        .in_mem_r   (in_mem_r),
        .in_mem_w   (in_mem_w),
        .in_dest    (in_dest),
        .alu_res    (alu_res),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .in_val_rm  (in_val_rm),
        .out_valid  (out_valid),
        .out_wb_en  (out_wb_en),
        .out_mem_r  (out_mem_r),
        .out_mem_w  (out_mem_w),
        .out_dest   (out_dest),
        .out_res    (out_res),
        .out_val_rm (out_val_rm),
        .sr         (sr),
        .carry_out  (carry_out),
        .retired    (retired)
    );

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait one rising edge, then settle before sampling/driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive an instruction on the EXE inputs
    task automatic drive(input logic v, input logic s, input logic wb, input logic mr,
                         input logic mw, input logic [3:0] dst, input logic [31:0] res,
                         input logic [3:0] nzcv, input logic [31:0] rm);
        in_valid  = v;
        in_s      = s;
        in_wb_en  = wb;
        in_mem_r  = mr;
        in_mem_w  = mw;
        in_dest   = dst;
        alu_res   = res;
        alu_n     = nzcv[3];
        alu_z     = nzcv[2];
        alu_c     = nzcv[1];
        alu_v     = nzcv[0];
        in_val_rm = rm;
    endtask

    task automatic check_zero(input string phase);
        check({phase, " out_valid"},  32'(out_valid),  32'd0);
        check({phase, " out_wb_en"},  32'(out_wb_en),  32'd0);
        check({phase, " out_mem_r"},  32'(out_mem_r),  32'd0);
        check({phase, " out_mem_w"},  32'(out_mem_w),  32'd0);
        check({phase, " out_dest"},   32'(out_dest),   32'd0);
        check({phase, " out_res"},    out_res,         32'd0);
        check({phase, " out_val_rm"}, out_val_rm,      32'd0);
        check({phase, " sr"},         32'(sr),         32'd0);
        check({phase, " carry_out"},  32'(carry_out),  32'd0);
        check({phase, " retired"},    32'(retired),    32'd0);
    endtask

    initial begin
        // Reset with random inputs for two cycles
        rst    = 1'b1;
        freeze = 1'($urandom_range(0, 1));
        flush  = 1'($urandom_range(0, 1));
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'($urandom), $urandom, 4'($urandom), $urandom);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'($urandom), $urandom, 4'($urandom), $urandom);
        step();
        check_zero("reset");

        // Flag-setting load
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h8000_0000, 4'b1011, 32'hDEAD_BEEF);
        step();
        check("load1 out_valid",  32'(out_valid), 32'd1);
        check("load1 out_wb_en",  32'(out_wb_en), 32'd1);
        check("load1 out_dest",   32'(out_dest),  32'd5);
        check("load1 out_res",    out_res,        32'h8000_0000);
        check("load1 out_val_rm", out_val_rm,     32'hDEAD_BEEF);
        check("load1 sr",         32'(sr),        32'b1011);
        check("load1 carry_out",  32'(carry_out), 32'd1);
        check("load1 retired",    32'(retired),   32'd1);

        // Non-S store: flags must not move
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h0000_1234, 4'b0100, 32'h0000_CAFE);
        step();
        check("nos sr",        32'(sr),        32'b1011);
        check("nos out_res",   out_res,        32'h0000_1234);
        check("nos out_mem_w", 32'(out_mem_w), 32'd1);
        check("nos out_wb_en", 32'(out_wb_en), 32'd0);
        check("nos retired",   32'(retired),   32'd2);

        // Freeze for three cycles with changing S-instructions
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'(i + 8), 32'h100 + 32'(i), 4'b0100, 32'(i));
            step();
            check("frz out_res",   out_res,        32'h0000_1234);
            check("frz out_dest",  32'(out_dest),  32'd3);
            check("frz out_mem_w", 32'(out_mem_w), 32'd1);
            check("frz sr",        32'(sr),        32'b1011);
            check("frz retired",   32'(retired),   32'd2);
        end

        // Release: the stalled instruction loads and writes flags once
        freeze = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 32'h0000_0055, 4'b0100, 32'h0000_0011);
        step();
        check("rel out_res",   out_res,        32'h0000_0055);
        check("rel out_mem_r", 32'(out_mem_r), 32'd1);
        check("rel sr",        32'(sr),        32'b0100);
        check("rel carry_out", 32'(carry_out), 32'd0);
        check("rel retired",   32'(retired),   32'd3);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 32'h0000_0066, 4'b1010, 32'h0000_0022);
        step();
        check("post sr",      32'(sr),      32'b0100);
        check("post retired", 32'(retired), 32'd4);

        // Flush together with freeze: bubble, data fields kept
        flush = 1'b1; freeze = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h0000_0077, 4'b1111, 32'h0000_0033);
        step();
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush out_mem_w", 32'(out_mem_w), 32'd0);
        check("flush out_wb_en", 32'(out_wb_en), 32'd0);
        check("flush out_res",   out_res,        32'h0000_0066);
        check("flush out_dest",  32'(out_dest),  32'd9);
        check("flush sr",        32'(sr),        32'b0100);
        check("flush retired",   32'(retired),   32'd4);

        // Non-valid input acts as a bubble
        flush = 1'b0; freeze = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h0000_0088, 4'b1111, 32'h0000_0044);
        step();
        check("idle out_valid", 32'(out_valid), 32'd0);
        check("idle out_mem_r", 32'(out_mem_r), 32'd0);
        check("idle out_res",   out_res,        32'h0000_0066);
        check("idle sr",        32'(sr),        32'b0100);
        check("idle retired",   32'(retired),   32'd4);

        // Mid-stream reset overrides flush/freeze
        rst = 1'b1; flush = 1'b1; freeze = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6, 32'h0000_0099, 4'b1111, 32'h0000_0055);
        step();
        check_zero("midrst");

        // Counter wrap with a 4-bit counter
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'(i), 32'(i), 4'b0000, 32'(i));
            step();
            if (i == 1) begin
                check("wrap first retired", 32'(retired), 32'd1);
                check("wrap first sr",      32'(sr),      32'd0);
            end
            if (i == 16) check("wrap16 retired", 32'(retired), 32'd0);
        end
        check("wrap17 retired", 32'(retired), 32'd1);
        check("wrap17 out_res", out_res,      32'd17);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
